// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock divider controller.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // Smallest divisor that still gives a period with both a high and a low phase.
  localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/clkdiv_halfext.sv
// Half-cycle extension stage: delays the rising-edge waveform by half a clk
// cycle and ORs it back in so odd divisors get an exact 50% duty cycle.
module clkdiv_halfext (
  input  logic clk,
  input  logic rst,
  input  logic p,
  input  logic odd,
  output logic out
);

  logic n;

  // The only falling-edge flop in the design; reset is sampled on this edge too.
  always_ff @(negedge clk) begin
    if (!rst) n <= 1'b0;
    else      n <= p;
  end

  assign out = odd ? (p | n) : p;

endmodule

// File: rtl/clkdiv_sched.sv
// Run-time programmable 50%-duty clock divider with divisor updates applied only
// at period boundaries and stop requests honoured only at the end of a period.
module clkdiv_sched
  import clkdiv_pkg::*;
#(
  parameter int unsigned CW          = 8,
  parameter int unsigned DIV_DEFAULT = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_div,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          out,
  output logic          tick,
  output logic          active
);

  state_t        state, state_d;
  logic [CW-1:0] div_cur, div_cur_d;
  logic [CW-1:0] div_nxt, div_nxt_d;
  logic [CW-1:0] cnt, cnt_d, cnt_nx;
  logic [CW-1:0] half;
  logic          p, p_d;
  logic          tick_d, err_d;
  logic          wrap, xfer, bad, take;

  assign half      = div_cur >> 1;
  assign wrap      = (cnt == div_cur - CW'(1));
  assign cfg_ready = (state != PEND);
  assign xfer      = cfg_valid && cfg_ready;
  assign bad       = (cfg_div < CW'(DIV_MIN));
  assign take      = xfer && !bad;
  assign active    = (state != IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state;
    div_cur_d = div_cur;
    div_nxt_d = div_nxt;
    cnt_d     = cnt;
    cnt_nx    = wrap ? '0 : cnt + CW'(1);
    p_d       = p;
    tick_d    = 1'b0;
    err_d     = xfer && bad;

    case (state)
      IDLE: begin
        cnt_d = '0;
        p_d   = 1'b0;
        if (take) div_cur_d = cfg_div;
        if (en) begin
          state_d = RUN;
          p_d     = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN, PEND: begin
        cnt_d = cnt_nx;
        p_d   = (cnt_nx < half);
        if (state == PEND && wrap) begin
          div_cur_d = div_nxt;
          state_d   = RUN;
        end
        // An update accepted on the wrap edge itself waits for the following wrap.
        if (state == RUN && take) begin
          div_nxt_d = cfg_div;
          state_d   = PEND;
        end
        if (wrap) begin
          if (en) begin
            tick_d = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            p_d     = 1'b0;
            if (state == RUN && take) div_cur_d = cfg_div;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        p_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      state   <= IDLE;
      div_cur <= CW'(DIV_DEFAULT);
      div_nxt <= '0;
      cnt     <= '0;
      p       <= 1'b0;
      tick    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_d;
      div_cur <= div_cur_d;
      div_nxt <= div_nxt_d;
      cnt     <= cnt_d;
      p       <= p_d;
      tick    <= tick_d;
      cfg_err <= err_d;
    end
  end

  clkdiv_halfext u_halfext (
    .clk (clk),
    .rst (rst),
    .p   (p),
    .odd (div_cur[0]),
    .out (out)
  );

endmodule

// File: tb/tb_clkdiv_sched.sv
// Directed bench for clkdiv_sched: output is sampled twice per clk cycle so
// half-cycle high times for odd divisors are visible in the recorded patterns.
module tb_clkdiv_sched;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       out;
  logic       tick;
  logic       active;

  int errors = 0;
  int checks = 0;

  clkdiv_sched #(.CW(8), .DIV_DEFAULT(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .out       (out),
    .tick      (tick),
    .active    (active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records, per cycle, out in both halves plus tick/cfg_ready/active/cfg_err.
  task automatic measure(input int cyc, output logic [63:0] op, output logic [31:0] tp,
                         output logic [31:0] rp, output logic [31:0] ap, output logic [31:0] ep);
    op = '0; tp = '0; rp = '0; ap = '0; ep = '0;
    for (int i = 0; i < cyc; i++) begin
      op = {op[62:0], out};
      tp = {tp[30:0], tick};
      rp = {rp[30:0], cfg_ready};
      ap = {ap[30:0], active};
      ep = {ep[30:0], cfg_err};
      @(negedge clk);
      #1;
      op = {op[62:0], out};
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    repeat (3) step();
    rst = 1'b1;
    step();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out got=%b exp=0", out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_default();
    logic [63:0] op; logic [31:0] tp, rp, ap, ep;
    en = 1'b1;
    step();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL default_active got=%b exp=1", active); end
    for (int k = 0; k < 2; k++) begin
      measure(7, op, tp, rp, ap, ep);
      checks++; if (op[13:0] !== 14'h3F80) begin errors++; $display("FAIL default_out%0d got=%h exp=3f80", k, op[13:0]); end
      checks++; if (tp[6:0] !== 7'b1000000) begin errors++; $display("FAIL default_tick%0d got=%b exp=1000000", k, tp[6:0]); end
    end
  endtask

  task automatic test_switch();
    logic [63:0] o1, o2, o3; logic [31:0] t1, t2, t3, r1, r2, r3, a, e;
    measure(2, o1, t1, r1, a, e);
    cfg_valid = 1'b1; cfg_div = 8'd4;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL switch_ready_pre got=%b exp=1", cfg_ready); end
    measure(1, o2, t2, r2, a, e);
    cfg_valid = 1'b0;
    measure(4, o3, t3, r3, a, e);
    checks++; if ({o1[3:0], o2[1:0], o3[7:0]} !== 14'h3F80) begin errors++; $display("FAIL switch_old_out got=%h exp=3f80", {o1[3:0], o2[1:0], o3[7:0]}); end
    checks++; if ({r1[1:0], r2[0], r3[3:0]} !== 7'b1110000) begin errors++; $display("FAIL switch_ready got=%b exp=1110000", {r1[1:0], r2[0], r3[3:0]}); end
    checks++; if ({t1[1:0], t2[0], t3[3:0]} !== 7'b1000000) begin errors++; $display("FAIL switch_old_tick got=%b exp=1000000", {t1[1:0], t2[0], t3[3:0]}); end
    measure(8, o1, t1, r1, a, e);
    checks++; if (o1[15:0] !== 16'hF0F0) begin errors++; $display("FAIL switch_new_out got=%h exp=f0f0", o1[15:0]); end
    checks++; if (t1[7:0] !== 8'b10001000) begin errors++; $display("FAIL switch_new_tick got=%b exp=10001000", t1[7:0]); end
    checks++; if (r1[7:0] !== 8'hFF) begin errors++; $display("FAIL switch_new_ready got=%h exp=ff", r1[7:0]); end
  endtask

  task automatic test_bad_cfg();
    logic [63:0] o1, o2; logic [31:0] t1, t2, r1, r2, a1, a2, e1, e2;
    cfg_valid = 1'b1; cfg_div = 8'd7;
    measure(1, o1, t1, r1, a1, e1);
    cfg_valid = 1'b0;
    measure(3, o2, t2, r2, a2, e2);
    checks++; if ({o1[1:0], o2[5:0]} !== 8'hF0) begin errors++; $display("FAIL restore_out got=%h exp=f0", {o1[1:0], o2[5:0]}); end
    checks++; if ({r1[0], r2[2:0]} !== 4'b1000) begin errors++; $display("FAIL restore_ready got=%b exp=1000", {r1[0], r2[2:0]}); end
    cfg_valid = 1'b1; cfg_div = 8'd1;
    measure(1, o1, t1, r1, a1, e1);
    cfg_valid = 1'b0;
    measure(6, o2, t2, r2, a2, e2);
    checks++; if ({e1[0], e2[5:0]} !== 7'b0100000) begin errors++; $display("FAIL bad_err got=%b exp=0100000", {e1[0], e2[5:0]}); end
    checks++; if ({r1[0], r2[5:0]} !== 7'h7F) begin errors++; $display("FAIL bad_ready got=%b exp=1111111", {r1[0], r2[5:0]}); end
    checks++; if ({o1[1:0], o2[11:0]} !== 14'h3F80) begin errors++; $display("FAIL bad_out got=%h exp=3f80", {o1[1:0], o2[11:0]}); end
    measure(7, o1, t1, r1, a1, e1);
    checks++; if (o1[13:0] !== 14'h3F80) begin errors++; $display("FAIL bad_next_out got=%h exp=3f80", o1[13:0]); end
    checks++; if (e1[6:0] !== 7'b0) begin errors++; $display("FAIL bad_next_err got=%b exp=0000000", e1[6:0]); end
  endtask

  task automatic test_stop();
    logic [63:0] o1, o2; logic [31:0] t1, t2, r, a1, a2, e;
    cfg_valid = 1'b1; cfg_div = 8'd6;
    measure(1, o1, t1, r, a1, e);
    cfg_valid = 1'b0;
    measure(6, o1, t1, r, a1, e);
    measure(1, o1, t1, r, a1, e);
    en = 1'b0;
    measure(5, o2, t2, r, a2, e);
    checks++; if ({o1[1:0], o2[9:0]} !== 12'hFC0) begin errors++; $display("FAIL stop_out got=%h exp=fc0", {o1[1:0], o2[9:0]}); end
    checks++; if ({t1[0], t2[4:0]} !== 6'b100000) begin errors++; $display("FAIL stop_tick got=%b exp=100000", {t1[0], t2[4:0]}); end
    checks++; if (a2[4:0] !== 5'b11111) begin errors++; $display("FAIL stop_active_run got=%b exp=11111", a2[4:0]); end
    measure(4, o1, t1, r, a1, e);
    checks++; if (a1[3:0] !== 4'b0000) begin errors++; $display("FAIL stop_active_after got=%b exp=0000", a1[3:0]); end
    checks++; if (o1[7:0] !== 8'h00) begin errors++; $display("FAIL stop_out_after got=%h exp=00", o1[7:0]); end
    checks++; if (t1[3:0] !== 4'b0000) begin errors++; $display("FAIL stop_tick_after got=%b exp=0000", t1[3:0]); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] op; logic [31:0] tp, rp, ap, ep;
    cfg_valid = 1'b1; cfg_div = 8'd3;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got=%b exp=1", cfg_ready); end
    step();
    cfg_div = 8'd5;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got=%b exp=1", cfg_ready); end
    step();
    cfg_valid = 1'b0; en = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      measure(5, op, tp, rp, ap, ep);
      checks++; if (op[9:0] !== 10'h3E0) begin errors++; $display("FAIL b2b_out%0d got=%h exp=3e0", k, op[9:0]); end
      checks++; if (tp[4:0] !== 5'b10000) begin errors++; $display("FAIL b2b_tick%0d got=%b exp=10000", k, tp[4:0]); end
      checks++; if (ep[4:0] !== 5'b00000) begin errors++; $display("FAIL b2b_err%0d got=%b exp=00000", k, ep[4:0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] op; logic [31:0] tp, rp, ap, ep;
    cfg_valid = 1'b1; cfg_div = 8'd3;
    measure(1, op, tp, rp, ap, ep);
    cfg_valid = 1'b0;
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL rstmid_out_pre got=%b exp=1", out); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_pre got=%b exp=0", cfg_ready); end
    rst = 1'b0;
    step();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL rstmid_active got=%b exp=0", active); end
    @(negedge clk);
    #1;
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL rstmid_out_fall got=%b exp=0", out); end
    @(posedge clk);
    #1;
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL rstmid_out_hold got=%b exp=0", out); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", cfg_ready); end
    rst = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      measure(7, op, tp, rp, ap, ep);
      checks++; if (op[13:0] !== 14'h3F80) begin errors++; $display("FAIL rstmid_out%0d got=%h exp=3f80", k, op[13:0]); end
      checks++; if (tp[6:0] !== 7'b1000000) begin errors++; $display("FAIL rstmid_tick%0d got=%b exp=1000000", k, tp[6:0]); end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_switch();
    test_bad_cfg();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    repeat (10) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
